// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants and FSM state type for the NTT controller
package ntt_pkg;

  // Modulus of the target ring; the controller itself only sequences addresses.
  localparam logic [22:0] Q         = 23'd8380417;
  localparam int          NTT_LOG_N = 8;
  localparam int          NTT_N     = 1 << NTT_LOG_N;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ntt_state_e;

endpackage

// File: rtl/ntt_addr_gen.sv
// rtl/ntt_addr_gen.sv - combinational butterfly operand and twiddle address map
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int  LOG_N = NTT_LOG_N,
  localparam int SW    = (LOG_N > 1) ? $clog2(LOG_N) : 1
) (
  input  logic [SW-1:0]    stage,
  input  logic [LOG_N-2:0] bfly,
  output logic [LOG_N-1:0] rd_addr_x,
  output logic [LOG_N-1:0] rd_addr_y,
  output logic [LOG_N-1:0] tf_addr
);

  localparam logic [LOG_N-1:0] HALF = LOG_N'(1) << (LOG_N - 1);

  logic [LOG_N-1:0] len;
  logic [LOG_N-1:0] grp;
  logic [LOG_N-1:0] ofs;
  logic [LOG_N-1:0] base;

  // Split the butterfly index into group and offset; group base is g*2*len,
  // done as a shift because len is always a power of two.
  always_comb begin
    len       = HALF >> stage;
    grp       = {1'b0, bfly} >> (LOG_N'(LOG_N - 1) - LOG_N'(stage));
    ofs       = {1'b0, bfly} & (len - LOG_N'(1));
    base      = grp << (LOG_N'(LOG_N) - LOG_N'(stage));
    rd_addr_x = base | ofs;
    rd_addr_y = rd_addr_x + len;
    tf_addr   = (LOG_N'(1) << stage) + grp;
  end

endmodule

// File: rtl/ntt_ctrl.sv
// rtl/ntt_ctrl.sv - forward Cooley-Tukey NTT sequencer: FSM, butterfly counter, write-back pipeline
module ntt_ctrl
  import ntt_pkg::*;
#(
  parameter int  LOG_N  = NTT_LOG_N,
  parameter int  RD_LAT = 1,
  localparam int SW     = (LOG_N > 1) ? $clog2(LOG_N) : 1,
  localparam int AW     = LOG_N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] stage,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_x,
  output logic [AW-1:0] rd_addr_y,
  output logic [AW-1:0] tf_addr,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr_x,
  output logic [AW-1:0] wr_addr_y
);

  localparam int BW = LOG_N - 1;
  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  ntt_state_e    state_q, state_d;
  logic [BW-1:0] b_q, b_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [DW-1:0] drain_q, drain_d;

  logic [AW-1:0] gen_x, gen_y, gen_tf;

  logic [RD_LAT-1:0] wen_pipe_q;
  logic [AW-1:0]     wx_pipe_q [RD_LAT];
  logic [AW-1:0]     wy_pipe_q [RD_LAT];

  ntt_addr_gen #(
    .LOG_N(LOG_N)
  ) u_addr_gen (
    .stage     (stage_q),
    .bfly      (b_q),
    .rd_addr_x (gen_x),
    .rd_addr_y (gen_y),
    .tf_addr   (gen_tf)
  );

  // Control state register; reset aborts any transform in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      b_q     <= '0;
      stage_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      stage_q <= stage_d;
      drain_q <= drain_d;
    end
  end

  // Next-state and strobes: one butterfly per RUN cycle, then RD_LAT idle
  // cycles so the stage's last write lands before the next stage reads.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    stage_d = stage_q;
    drain_d = drain_q;
    rd_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        b_d     = '0;
        stage_d = '0;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (b_q == {BW{1'b1}}) begin
          b_d     = '0;
          drain_d = '0;
          state_d = ST_DRAIN;
        end else begin
          b_d = b_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_q == DW'(RD_LAT - 1)) begin
          drain_d = '0;
          if (stage_q == SW'(LOG_N - 1)) begin
            state_d = ST_DONE;
          end else begin
            stage_d = stage_q + 1'b1;
            state_d = ST_RUN;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        stage_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Addresses are forced to zero whenever no read is issued.
  assign stage     = stage_q;
  assign rd_addr_x = rd_en ? gen_x  : '0;
  assign rd_addr_y = rd_en ? gen_y  : '0;
  assign tf_addr   = rd_en ? gen_tf : '0;

  // Write-back pipeline: read strobe and addresses delayed by the memory read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_pipe_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        wx_pipe_q[i] <= '0;
        wy_pipe_q[i] <= '0;
      end
    end else begin
      wen_pipe_q[0] <= rd_en;
      wx_pipe_q[0]  <= rd_addr_x;
      wy_pipe_q[0]  <= rd_addr_y;
      for (int i = 1; i < RD_LAT; i++) begin
        wen_pipe_q[i] <= wen_pipe_q[i-1];
        wx_pipe_q[i]  <= wx_pipe_q[i-1];
        wy_pipe_q[i]  <= wy_pipe_q[i-1];
      end
    end
  end

  assign wr_en     = wen_pipe_q[RD_LAT-1];
  assign wr_addr_x = wx_pipe_q[RD_LAT-1];
  assign wr_addr_y = wy_pipe_q[RD_LAT-1];

endmodule
